aquarium_monitor_seq: RTL and testbench

AQUARIUM_MONITOR_SEQ -- requirements
Module: aquarium_monitor_seq

---
 rtl/aquarium_monitor_seq.sv | 162 ++++++++++++++++
 tb/tb_aquarium_monitor_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aquarium_monitor_seq.sv
// Aquarium sensor scan sequencer. Requests one sample from each of the four channels,
// loads it into its tank register, checks its limits, then shows that channel on the display mux.
module aquarium_monitor_seq #(
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       clr_err,
  input  logic       sample_valid,
  input  logic [7:0] sensor_data,
  input  logic [7:0] lim_lo,
  input  logic [7:0] lim_hi,
  output logic       sample_req,
  output logic [1:0] sensor_ch,
  output logic [3:0] ld_en,
  output logic [7:0] data_out,
  output logic [4:0] mux_sel,
  output logic [7:0] scan_cnt,
  output logic [3:0] alarm,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [7:0] DWELL_LAST   = 8'(DWELL - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] ch;
  logic [7:0] req_timer;
  logic [7:0] dwell_timer;
  logic       ready;
  logic       req_expired;
  logic       dwell_done;

  assign req_expired = (req_timer == TIMEOUT_LAST);
  assign dwell_done  = (dwell_timer == DWELL_LAST);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ready holds off the first request by one edge after reset is released
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && ready) state_next = REQ;
      end
      REQ: begin
        if (sample_valid)     state_next = LOAD;
        else if (req_expired) state_next = ERROR;
      end
      LOAD: begin
        state_next = SHOW;
      end
      SHOW: begin
        if (dwell_done) begin
          if (ch != 2'd3) state_next = REQ;
          else if (start) state_next = REQ;
          else            state_next = IDLE;
        end
      end
      ERROR: begin
        if (clr_err) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ready       <= 1'b0;
      ch          <= 2'd0;
      req_timer   <= 8'd0;
      dwell_timer <= 8'd0;
      data_out    <= 8'd0;
      scan_cnt    <= 8'd0;
      alarm       <= 4'd0;
    end else begin
      ready <= 1'b1;
      case (state)
        IDLE: begin
          ch          <= 2'd0;
          req_timer   <= 8'd0;
          dwell_timer <= 8'd0;
        end
        REQ: begin
          if (sample_valid) begin
            data_out  <= sensor_data;
            req_timer <= 8'd0;
          end else if (req_expired) begin
            req_timer <= 8'd0;
          end else begin
            req_timer <= req_timer + 8'd1;
          end
        end
        LOAD: begin
          alarm[ch]   <= (data_out < lim_lo) | (data_out > lim_hi);
          dwell_timer <= 8'd0;
        end
        SHOW: begin
          if (dwell_done) begin
            dwell_timer <= 8'd0;
            if (ch == 2'd3) begin
              scan_cnt <= scan_cnt + 8'd1;
              ch       <= 2'd0;
            end else begin
              ch <= ch + 2'd1;
            end
          end else begin
            dwell_timer <= dwell_timer + 8'd1;
          end
        end
        ERROR: begin
          ch        <= 2'd0;
          req_timer <= 8'd0;
        end
        default: begin
          ch <= 2'd0;
        end
      endcase
    end
  end

  // Outputs come only from registered state, so no input reaches an output combinationally
  always_comb begin
    sample_req = (state == REQ);
    sensor_ch  = ch;
    ld_en      = 4'b0000;
    mux_sel    = 5'b00000;
    busy       = (state == REQ) || (state == LOAD) || (state == SHOW);
    err        = (state == ERROR);
    case (state)
      REQ:     mux_sel = 5'b00001;
      LOAD: begin
        mux_sel   = 5'b00001;
        ld_en[ch] = 1'b1;
      end
      SHOW:    mux_sel = 5'b00010 << ch;
      ERROR:   mux_sel = 5'b11111;
      default: mux_sel = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_aquarium_monitor_seq.sv
// Directed bench for aquarium_monitor_seq: scans, alarms, limit boundaries, timeout,
// start drop, counter wrap and reset during LOAD, all against hand-computed values.
module tb_aquarium_monitor_seq;

  localparam int DWELL = 4;

  logic       CLK;
  logic       reset;
  logic       start;
  logic       clr_err;
  logic       sample_valid;
  logic [7:0] sensor_data;
  logic [7:0] lim_lo;
  logic [7:0] lim_hi;
  logic       sample_req;
  logic [1:0] sensor_ch;
  logic [3:0] ld_en;
  logic [7:0] data_out;
  logic [4:0] mux_sel;
  logic [7:0] scan_cnt;
  logic [3:0] alarm;
  logic       busy;
  logic       err;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  int t_first;

  aquarium_monitor_seq #(.DWELL(DWELL), .TIMEOUT(16)) dut (
    .CLK(CLK), .reset(reset), .start(start), .clr_err(clr_err),
    .sample_valid(sample_valid), .sensor_data(sensor_data),
    .lim_lo(lim_lo), .lim_hi(lim_hi), .sample_req(sample_req),
    .sensor_ch(sensor_ch), .ld_en(ld_en), .data_out(data_out),
    .mux_sel(mux_sel), .scan_cnt(scan_cnt), .alarm(alarm),
    .busy(busy), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_compared++;
    if (got !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Entered at the negedge of the first REQ cycle of channel c; leaves at the negedge after its SHOW.
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] d, input int wait_cyc,
                               input logic [3:0] exp_alarm, input bit drop_start);
    logic [3:0] exp_ld;
    logic [4:0] exp_mux;
    exp_ld  = 4'b0001 << c;
    exp_mux = 5'b00010 << c;
    checkOutput("req_sample_req", sample_req, 1);
    checkOutput("req_sensor_ch", sensor_ch, c);
    checkOutput("req_mux", mux_sel, 5'b00001);
    for (int i = 0; i < wait_cyc; i++) begin
      sample_valid = 1'b0;
      step();
      checkOutput("req_wait_err", err, 0);
      checkOutput("req_wait_req", sample_req, 1);
    end
    sample_valid = 1'b1;
    sensor_data  = d;
    step();
    checkOutput("load_ld_en", ld_en, exp_ld);
    checkOutput("load_data_out", data_out, d);
    checkOutput("load_mux", mux_sel, 5'b00001);
    checkOutput("load_err", err, 0);
    sample_valid = 1'b0;
    step();
    for (int i = 0; i < DWELL; i++) begin
      checkOutput("show_mux", mux_sel, exp_mux);
      checkOutput("show_ld_en", ld_en, 0);
      checkOutput("show_data_hold", data_out, d);
      checkOutput("show_alarm", alarm, exp_alarm);
      if (drop_start && i == 0) start = 1'b0;
      sample_valid = (i < DWELL - 1);
      sensor_data  = ~d;
      step();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clr_err = 1'b0; sample_valid = 1'b0;
    sensor_data = 8'd0; lim_lo = 8'd10; lim_hi = 8'd200;
    step();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_mux", mux_sel, 0);
    checkOutput("rst_ld_en", ld_en, 0);
    checkOutput("rst_sample_req", sample_req, 0);
    checkOutput("rst_scan_cnt", scan_cnt, 0);
    checkOutput("rst_alarm", alarm, 0);
    checkOutput("rst_data_out", data_out, 0);

    reset = 1'b0; start = 1'b1;
    step();
    checkOutput("first_edge_idle", busy, 0);
    checkOutput("first_edge_mux", mux_sel, 0);
    step();
    t_first = cyc;

    // Normal scan, all in range
    applyStimulus(2'd0, 8'd14, 0, 4'b0000, 0);
    applyStimulus(2'd1, 8'd28, 0, 4'b0000, 0);
    applyStimulus(2'd2, 8'd56, 0, 4'b0000, 0);
    applyStimulus(2'd3, 8'd112, 0, 4'b0000, 0);
    checkOutput("scan1_len", cyc - t_first, 24);
    checkOutput("scan1_cnt", scan_cnt, 1);

    // Alarm scan; clr_err is ignored outside ERROR
    clr_err = 1'b1;
    applyStimulus(2'd0, 8'd100, 0, 4'b0000, 0);
    clr_err = 1'b0;
    applyStimulus(2'd1, 8'd5, 0, 4'b0010, 0);
    applyStimulus(2'd2, 8'd100, 0, 4'b0010, 0);
    applyStimulus(2'd3, 8'd250, 0, 4'b1010, 0);
    checkOutput("scan2_cnt", scan_cnt, 2);

    // Boundary data on the limits, valid on the 16th REQ cycle
    applyStimulus(2'd0, 8'd10, 0, 4'b1010, 0);
    applyStimulus(2'd1, 8'd100, 15, 4'b1000, 0);
    applyStimulus(2'd2, 8'd200, 0, 4'b1000, 0);
    applyStimulus(2'd3, 8'd100, 0, 4'b0000, 0);
    checkOutput("scan3_cnt", scan_cnt, 3);

    // start drops during ch1 SHOW; scan still completes
    applyStimulus(2'd0, 8'd50, 0, 4'b0000, 0);
    applyStimulus(2'd1, 8'd50, 0, 4'b0000, 1);
    applyStimulus(2'd2, 8'd50, 0, 4'b0000, 0);
    applyStimulus(2'd3, 8'd50, 0, 4'b0000, 0);
    checkOutput("drop_idle_busy", busy, 0);
    checkOutput("drop_idle_mux", mux_sel, 0);
    checkOutput("drop_scan_cnt", scan_cnt, 4);
    step(); step();
    checkOutput("drop_stay_idle", sample_req, 0);

    // Counter wrap with continuous valid
    start = 1'b1; sample_valid = 1'b1; sensor_data = 8'd100;
    step();
    repeat (251 * 24) step();
    checkOutput("wrap_cnt_255", scan_cnt, 255);
    checkOutput("wrap_req_ch", sensor_ch, 0);
    repeat (24) step();
    checkOutput("wrap_cnt_0", scan_cnt, 0);
    checkOutput("wrap_req", sample_req, 1);
    start = 1'b0;
    repeat (24) step();
    checkOutput("wrap_cnt_1", scan_cnt, 1);
    checkOutput("wrap_idle", busy, 0);
    sample_valid = 1'b0;

    // Timeout in REQ ch2
    start = 1'b1;
    step();
    applyStimulus(2'd0, 8'd100, 0, 4'b0000, 0);
    applyStimulus(2'd1, 8'd100, 0, 4'b0000, 0);
    checkOutput("to_ch", sensor_ch, 2);
    for (int i = 0; i < 15; i++) begin
      step();
      checkOutput("to_wait_err", err, 0);
    end
    step();
    checkOutput("to_err", err, 1);
    checkOutput("to_mux", mux_sel, 5'b11111);
    checkOutput("to_ld_en", ld_en, 0);
    checkOutput("to_sample_req", sample_req, 0);
    checkOutput("to_busy", busy, 0);
    repeat (3) step();
    checkOutput("to_hold_err", err, 1);
    checkOutput("to_hold_ld_en", ld_en, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0; start = 1'b0;
    checkOutput("clr_err_low", err, 0);
    checkOutput("clr_mux", mux_sel, 0);
    checkOutput("clr_busy", busy, 0);

    // Reset pulse during LOAD ch2
    start = 1'b1;
    step();
    applyStimulus(2'd0, 8'd5, 0, 4'b0001, 0);
    applyStimulus(2'd1, 8'd100, 0, 4'b0001, 0);
    sample_valid = 1'b1; sensor_data = 8'd77;
    step();
    checkOutput("prerst_ld_en", ld_en, 4'b0100);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_ld_en", ld_en, 0);
    checkOutput("midrst_data_out", data_out, 0);
    checkOutput("midrst_scan_cnt", scan_cnt, 0);
    checkOutput("midrst_alarm", alarm, 0);
    checkOutput("midrst_mux", mux_sel, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_sensor_ch", sensor_ch, 0);
    checkOutput("midrst_sample_req", sample_req, 0);
    sample_valid = 1'b0;
    step();
    checkOutput("rst_hold_ld_en", ld_en, 0);
    reset = 1'b0; start = 1'b1;
    step();
    checkOutput("rel_first_edge", busy, 0);
    step();
    checkOutput("rel_req", sample_req, 1);
    checkOutput("rel_ch", sensor_ch, 0);
    checkOutput("rel_ld_en", ld_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
